data_pipe_interconnect_s2m_prio: RTL and testbench



---
 rtl/data_pipe_interconnect_s2m_prio.sv | 120 ++++++++++++
 tb/tb_data_pipe_interconnect_s2m_prio.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_pipe_interconnect_s2m_prio.sv
// Single-slave to multi-master dispatcher: one upstream stream is steered to m00[curr_path]
// through a two-entry skid (connector + overflow buffer) so the upstream ready is a flop.
module data_pipe_interconnect_s2m_prio #(
    parameter int DSIZE = 8,
    parameter int NUM   = 8,
    parameter int NSIZE = (NUM <= 2) ? 1 : (NUM <= 4) ? 2 : (NUM <= 8) ? 3 : (NUM <= 16) ? 4 : 5
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic                       vld_sw,
    input  logic [NSIZE-1:0]           sw,
    output logic [NSIZE-1:0]           curr_path,
    input  logic [NUM-1:0]             prio,
    output logic                       over_flow,
    input  logic                       s00_valid,
    output logic                       s00_ready,
    input  logic [DSIZE-1:0]           s00_data,
    output logic [NUM-1:0]             m00_valid,
    input  logic [NUM-1:0]             m00_ready,
    output logic [NUM-1:0][DSIZE-1:0]  m00_data
);

    typedef enum logic [2:0] {
        IDLE,
        EMPTY,
        ONE,
        TWO,
        OVER_FLOW
    } state_t;

    state_t             state_q, state_d;
    logic [DSIZE-1:0]   conn_q, conn_d;
    logic [DSIZE-1:0]   buf_q, buf_d;
    logic [NSIZE-1:0]   path_q, path_d;
    logic               s00_ready_q, s00_ready_d;

    logic               conn_vld;
    logic               xfer_in;
    logic               xfer_out;

    assign conn_vld  = (state_q == ONE) || (state_q == TWO);
    assign xfer_in   = s00_valid & s00_ready_q & clk_en;
    assign xfer_out  = clk_en & (|(m00_valid & m00_ready));

    assign s00_ready = s00_ready_q;
    assign curr_path = path_q;
    assign over_flow = (state_q == OVER_FLOW);

    // Only valid is steered; data is broadcast to every master.
    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_out
            assign m00_valid[gi] = conn_vld & (path_q == NSIZE'(gi));
            assign m00_data[gi]  = conn_q;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        conn_d      = conn_q;
        buf_d       = buf_q;
        path_d      = path_q;
        s00_ready_d = s00_ready_q;
        if (clk_en) begin
            case (state_q)
                IDLE: state_d = EMPTY;
                EMPTY: begin
                    if (xfer_in) begin
                        state_d = ONE;
                        conn_d  = s00_data;
                    end
                end
                ONE: begin
                    if (xfer_in && !xfer_out) begin
                        state_d = TWO;
                        buf_d   = s00_data;
                    end else if (!xfer_in && xfer_out) begin
                        state_d = EMPTY;
                    end else if (xfer_in && xfer_out) begin
                        conn_d  = s00_data;
                    end
                end
                TWO: begin
                    if (xfer_out) begin
                        state_d = ONE;
                        conn_d  = buf_q;
                        buf_d   = '0;
                    end else if (xfer_in) begin
                        state_d = OVER_FLOW;
                    end
                end
                OVER_FLOW: state_d = OVER_FLOW;
                default:   state_d = IDLE;
            endcase
            // Destination may only move while nothing is held, so a beat never changes port.
            if ((state_d == IDLE) || (state_d == EMPTY)) begin
                path_d = sw;
            end
            s00_ready_d = ((state_d == EMPTY) || (state_d == ONE)) & vld_sw & prio[path_d];
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            conn_q      <= '0;
            buf_q       <= '0;
            path_q      <= '0;
            s00_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            conn_q      <= conn_d;
            buf_q       <= buf_d;
            path_q      <= path_d;
            s00_ready_q <= s00_ready_d;
        end
    end

endmodule

// File: tb/tb_data_pipe_interconnect_s2m_prio.sv
// Scoreboard bench for data_pipe_interconnect_s2m_prio: beats are queued with their intended
// destination on upstream acceptance and popped when a downstream handshake occurs.
module tb_data_pipe_interconnect_s2m_prio;

    localparam int DSIZE = 8;
    localparam int NUM   = 8;
    localparam int NSIZE = 3;

    typedef struct packed {
        logic [NSIZE-1:0] dest;
        logic [DSIZE-1:0] data;
    } beat_t;

    logic                      clock = 1'b0;
    logic                      rst_n = 1'b1;
    logic                      clk_en = 1'b1;
    logic                      vld_sw = 1'b1;
    logic [NSIZE-1:0]          sw = '0;
    logic [NSIZE-1:0]          curr_path;
    logic [NUM-1:0]            prio = 8'hFF;
    logic                      over_flow;
    logic                      s00_valid = 1'b0;
    logic                      s00_ready;
    logic [DSIZE-1:0]          s00_data = '0;
    logic [NUM-1:0]            m00_valid;
    logic [NUM-1:0]            m00_ready = '0;
    logic [NUM-1:0][DSIZE-1:0] m00_data;

    beat_t src_q[$];
    beat_t sb_q[$];

    int checks = 0;
    int failures = 0;
    int n_in = 0;
    int n_out = 0;
    int cyc_no = 0;
    int first_in = -1;
    int last_in = -1;

    always #5 clock = ~clock;

    data_pipe_interconnect_s2m_prio #(
        .DSIZE(DSIZE),
        .NUM  (NUM),
        .NSIZE(NSIZE)
    ) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .vld_sw   (vld_sw),
        .sw       (sw),
        .curr_path(curr_path),
        .prio     (prio),
        .over_flow(over_flow),
        .s00_valid(s00_valid),
        .s00_ready(s00_ready),
        .s00_data (s00_data),
        .m00_valid(m00_valid),
        .m00_ready(m00_ready),
        .m00_data (m00_data)
    );

    function automatic void drive();
        s00_valid = (src_q.size() > 0);
        s00_data  = (src_q.size() > 0) ? src_q[0].data : '0;
    endfunction

    // One clock cycle: apply inputs, observe handshakes mid-low-phase, then return at negedge.
    task automatic cyc();
        beat_t b;
        drive();
        #2;
        cyc_no++;
        if (rst_n && clk_en && s00_valid && s00_ready) begin
            if (src_q.size() > 0) begin
                b = src_q.pop_front();
                sb_q.push_back(b);
                $display("[%0t] in  dest=%0d data=%h", $time, b.dest, b.data);
            end
            n_in++;
            if (first_in < 0) first_in = cyc_no;
            last_in = cyc_no;
        end
        checks++;
        if ($countones(m00_valid) > 1) begin
            failures++;
            $display("FAIL onehot_valid: m00_valid=%b, required at most one bit set", m00_valid);
        end
        for (int k = 0; k < NUM; k++) begin
            if (rst_n && clk_en && m00_valid[k] && m00_ready[k]) begin
                checks++;
                n_out++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: port=%0d data=%h, required no output", k, m00_data[k]);
                end else begin
                    b = sb_q.pop_front();
                    $display("[%0t] out port=%0d data=%h", $time, k, m00_data[k]);
                    if (b.dest !== k[NSIZE-1:0] || b.data !== m00_data[k]) begin
                        failures++;
                        $display("FAIL out_beat: port=%0d data=%h, required port=%0d data=%h",
                                 k, m00_data[k], b.dest, b.data);
                    end
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic drain(input int max, input string name);
        int n = 0;
        while ((src_q.size() > 0 || sb_q.size() > 0) && n < max) begin
            cyc();
            n++;
        end
        checks++;
        if (src_q.size() > 0 || sb_q.size() > 0) begin
            failures++;
            $display("FAIL %s_timeout: pending src=%0d sb=%0d, required 0 and 0", name, src_q.size(), sb_q.size());
            src_q.delete();
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks += 5;
        if (s00_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b, required 0", s00_ready); end
        if (m00_valid !== '0) begin failures++; $display("FAIL rst_valid: got %b, required 0", m00_valid); end
        if (m00_data !== '0) begin failures++; $display("FAIL rst_data: got %h, required 0", m00_data); end
        if (curr_path !== '0) begin failures++; $display("FAIL rst_path: got %0d, required 0", curr_path); end
        if (over_flow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b, required 0", over_flow); end
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_streaming();
        int n0;
        sw = 3'd3;
        prio = 8'hFF;
        m00_ready = 8'h08;
        idle(3);
        n0 = n_out;
        first_in = -1;
        for (int i = 1; i <= 16; i++) src_q.push_back('{dest: 3'd3, data: 8'(i)});
        drain(60, "stream");
        checks += 2;
        if (n_out - n0 != 16) begin failures++; $display("FAIL stream_count: got %0d beats, required 16", n_out - n0); end
        if (last_in - first_in != 15) begin
            failures++;
            $display("FAIL stream_rate: accept span %0d cycles, required 15", last_in - first_in);
        end
    endtask

    task automatic test_skid();
        int n0;
        sw = 3'd2;
        m00_ready = '0;
        idle(3);
        n0 = n_in;
        src_q.push_back('{dest: 3'd2, data: 8'hA0});
        src_q.push_back('{dest: 3'd2, data: 8'hA1});
        src_q.push_back('{dest: 3'd2, data: 8'hA2});
        cyc();
        cyc();
        repeat (5) begin
            cyc();
            checks++;
            if (s00_ready !== 1'b0) begin failures++; $display("FAIL skid_ready: got %b, required 0", s00_ready); end
        end
        checks += 3;
        if (n_in - n0 != 2) begin failures++; $display("FAIL skid_held: got %0d accepted, required 2", n_in - n0); end
        if (m00_valid !== 8'h04) begin failures++; $display("FAIL skid_valid: got %b, required 00000100", m00_valid); end
        if (m00_data[2] !== 8'hA0) begin failures++; $display("FAIL skid_head: got %h, required a0", m00_data[2]); end
        m00_ready = 8'h04;
        drain(20, "skid");
    endtask

    task automatic test_path_hold();
        sw = 3'd1;
        m00_ready = '0;
        idle(3);
        src_q.push_back('{dest: 3'd1, data: 8'h55});
        cyc();
        sw = 3'd5;
        idle(3);
        checks += 3;
        if (curr_path !== 3'd1) begin failures++; $display("FAIL hold_path: got %0d, required 1", curr_path); end
        if (m00_valid !== 8'h02) begin failures++; $display("FAIL hold_valid: got %b, required 00000010", m00_valid); end
        if (m00_data[1] !== 8'h55) begin failures++; $display("FAIL hold_data: got %h, required 55", m00_data[1]); end
        m00_ready = 8'h22;
        drain(10, "hold_old");
        idle(2);
        checks++;
        if (curr_path !== 3'd5) begin failures++; $display("FAIL switch_path: got %0d, required 5", curr_path); end
        src_q.push_back('{dest: 3'd5, data: 8'h66});
        drain(10, "hold_new");
    endtask

    task automatic test_prio();
        int n0;
        sw = 3'd4;
        prio = 8'hEF;
        m00_ready = 8'h10;
        idle(3);
        n0 = n_in;
        src_q.push_back('{dest: 3'd4, data: 8'h77});
        repeat (4) begin
            cyc();
            checks++;
            if (s00_ready !== 1'b0) begin failures++; $display("FAIL prio_gate: ready %b, required 0", s00_ready); end
        end
        checks++;
        if (n_in != n0) begin failures++; $display("FAIL prio_accept: got %0d accepted, required 0", n_in - n0); end
        prio = 8'hFF;
        cyc();
        checks++;
        if (s00_ready !== 1'b1) begin failures++; $display("FAIL prio_rise: ready %b, required 1", s00_ready); end
        drain(10, "prio");
    endtask

    task automatic test_clk_en();
        int n0i;
        int n0o;
        sw = 3'd6;
        m00_ready = '0;
        idle(3);
        src_q.push_back('{dest: 3'd6, data: 8'h31});
        cyc();
        src_q.push_back('{dest: 3'd6, data: 8'h32});
        clk_en = 1'b0;
        m00_ready = 8'h40;
        n0i = n_in;
        n0o = n_out;
        repeat (3) begin
            cyc();
            checks += 3;
            if (s00_ready !== 1'b1) begin failures++; $display("FAIL en_ready: got %b, required 1", s00_ready); end
            if (m00_valid !== 8'h40) begin failures++; $display("FAIL en_valid: got %b, required 01000000", m00_valid); end
            if (m00_data[6] !== 8'h31) begin failures++; $display("FAIL en_data: got %h, required 31", m00_data[6]); end
        end
        checks++;
        if (n_in != n0i || n_out != n0o) begin
            failures++;
            $display("FAIL en_xfer: got in=%0d out=%0d, required 0 0", n_in - n0i, n_out - n0o);
        end
        clk_en = 1'b1;
        drain(10, "clk_en");
    endtask

    task automatic test_reset_midstream();
        sw = 3'd2;
        m00_ready = '0;
        idle(3);
        src_q.push_back('{dest: 3'd2, data: 8'h81});
        src_q.push_back('{dest: 3'd2, data: 8'h82});
        src_q.push_back('{dest: 3'd2, data: 8'h83});
        cyc();
        cyc();
        #3 rst_n = 1'b0;
        #1;
        checks += 5;
        if (s00_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready: got %b, required 0", s00_ready); end
        if (m00_valid !== '0) begin failures++; $display("FAIL mid_rst_valid: got %b, required 0", m00_valid); end
        if (m00_data !== '0) begin failures++; $display("FAIL mid_rst_data: got %h, required 0", m00_data); end
        if (curr_path !== '0) begin failures++; $display("FAIL mid_rst_path: got %0d, required 0", curr_path); end
        if (over_flow !== 1'b0) begin failures++; $display("FAIL mid_rst_overflow: got %b, required 0", over_flow); end
        src_q.delete();
        sb_q.delete();
        drive();
        @(negedge clock);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_overflow();
        sw = 3'd7;
        m00_ready = '0;
        idle(3);
        src_q.push_back('{dest: 3'd7, data: 8'hC0});
        src_q.push_back('{dest: 3'd7, data: 8'hC1});
        src_q.push_back('{dest: 3'd7, data: 8'hC2});
        cyc();
        cyc();
        force dut.s00_ready_q = 1'b1;
        cyc();
        release dut.s00_ready_q;
        checks++;
        if (over_flow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b, required 1", over_flow); end
        src_q.delete();
        idle(2);
        m00_ready = 8'hFF;
        src_q.push_back('{dest: 3'd7, data: 8'hDD});
        repeat (4) begin
            cyc();
            checks += 3;
            if (over_flow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b, required 1", over_flow); end
            if (m00_valid !== '0) begin failures++; $display("FAIL ovf_valid: got %b, required 0", m00_valid); end
            if (s00_ready !== 1'b0) begin failures++; $display("FAIL ovf_ready: got %b, required 0", s00_ready); end
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (over_flow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b, required 0", over_flow); end
        src_q.delete();
        sb_q.delete();
        drive();
        @(negedge clock);
        rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_path_hold();
        test_prio();
        test_clk_en();
        test_reset_midstream();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
